// File: rtl/demux1to2_buf.sv
// demux1to2_buf: one valid/ready stream steered by `control` into two FIFO-buffered ports.
// Define DEMUX_STATS_EN to add the cnt0/cnt1 delivered-word counters.
module demux1to2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             control,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [31:0]      cnt0,
  output logic [31:0]      cnt1
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]            full;
  logic [1:0]            nonempty;
  logic [1:0]            rdy;
  logic [1:0][WIDTH-1:0] head;
`ifdef DEMUX_STATS_EN
  logic [1:0][31:0]      cnt;
`endif

  assign rdy = {out1_ready, out0_ready};

  // Only registered occupancy feeds in_ready, so sinks never gate the source.
  assign in_ready = !full[control];

  for (genvar i = 0; i < 2; i++) begin : g_port
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      occ;
    logic             push;
    logic             pop;

    assign push        = in_valid && !full[i] && (control == 1'(i));
    assign pop         = nonempty[i] && rdy[i];
    assign full[i]     = (occ == (AW+1)'(DEPTH));
    assign nonempty[i] = (occ != '0);
    assign head[i]     = nonempty[i] ? mem[rp] : '0;

    always_ff @(posedge clk) begin
      if (push) mem[wp] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wp  <= '0;
        rp  <= '0;
        occ <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
        unique case ({push, pop})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
      end
    end

`ifdef DEMUX_STATS_EN
    logic [31:0] c;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)      c <= '0;
      else if (pop) c <= c + 32'd1;
    end

    assign cnt[i] = c;
`endif
  end

  assign out0_data  = head[0];
  assign out1_data  = head[1];
  assign out0_valid = nonempty[0];
  assign out1_valid = nonempty[1];

`ifdef DEMUX_STATS_EN
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
`endif

endmodule

// File: tb/tb_demux1to2_buf.sv
// tb_demux1to2_buf: directed stimulus with per-port expected-word queues.
// A negedge monitor pops and compares every word the DUT hands off.
module tb_demux1to2_buf;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        control;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
`ifdef DEMUX_STATS_EN
  logic [31:0] cnt0;
  logic [31:0] cnt1;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];

  demux1to2_buf #(.WIDTH(32), .DEPTH(4)) dut (
`ifdef DEMUX_STATS_EN
    .cnt0(cnt0),
    .cnt1(cnt1),
`endif
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .control(control),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out0_data(out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data(out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_valid && out0_ready) begin
        if (exp0.size() == 0) chk("out0_unexpected", out0_data, 32'hxxxxxxxx);
        else chk("out0_data", out0_data, exp0.pop_front());
      end
      if (!out0_valid) chk("out0_idle_zero", out0_data, 32'h0);
      if (out1_valid && out1_ready) begin
        if (exp1.size() == 0) chk("out1_unexpected", out1_data, 32'hxxxxxxxx);
        else chk("out1_data", out1_data, exp1.pop_front());
      end
      if (!out1_valid) chk("out1_idle_zero", out1_data, 32'h0);
    end
  end

  task automatic push(input logic ctl, input logic [31:0] d);
    bit done = 0;
    in_valid = 1;
    control  = ctl;
    in_data  = d;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (ctl) exp1.push_back(d);
        else     exp0.push_back(d);
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) chk("push_timeout", 32'(done), 32'd1);
    in_valid = 0;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge clk);
      #1;
      if (exp0.size() == 0 && exp1.size() == 0) done = 1;
    end
    chk({name, "_drained"}, 32'(done), 32'd1);
    chk({name, "_v0_low"}, 32'(out0_valid), 32'd0);
    chk({name, "_v1_low"}, 32'(out1_valid), 32'd0);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #2 rst = 1;
    exp0.delete();
    exp1.delete();
    repeat (2) @(posedge clk);
    #2 rst = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; control = 0; in_data = 0;
    out0_ready = 1; out1_ready = 1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_v0", 32'(out0_valid), 32'd0);
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_d0", out0_data, 32'h0);
    chk("rst_d1", out1_data, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 0;

    // Basic routing, one-cycle latency, single-cycle valid
    push(0, 32'hAAAA0001);
    chk("t1_v0_next", 32'(out0_valid), 32'd1);
    push(1, 32'hBBBB0002);
    chk("t1_v1_next", 32'(out1_valid), 32'd1);
    @(negedge clk);
    chk("t1_v0_once", 32'(out0_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_v1_once", 32'(out1_valid), 32'd0);
    drain("t1");

    // Fill port0, other port unaffected
    out0_ready = 0;
    for (int k = 0; k < 4; k++) push(0, 32'h10 + 32'(k));
    control = 0;
    #1 chk("t2_full_rdy", 32'(in_ready), 32'd0);
    control = 1;
    #1 chk("t2_other_rdy", 32'(in_ready), 32'd1);
    push(1, 32'h20);

    // Full with simultaneous pop: push refused, accepted next cycle
    in_valid = 1; control = 0; in_data = 32'h14;
    #1;
    out0_ready = 1;
    chk("t3_refused", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("t3_rdy_after", 32'(in_ready), 32'd1);
    push(0, 32'h14);
    drain("t3");

    // Wrap-around with toggling sink
    out1_ready = 1;
    fork
      for (int k = 0; k < 10; k++) push(1, 32'(k));
      repeat (30) begin
        @(posedge clk);
        #1 out1_ready = ~out1_ready;
      end
    join
    out1_ready = 1;
    drain("t4");

    // Asynchronous reset mid-operation
    out0_ready = 0; out1_ready = 0;
    for (int k = 0; k < 3; k++) push(0, 32'h30 + 32'(k));
    for (int k = 0; k < 2; k++) push(1, 32'h40 + 32'(k));
    @(posedge clk);
    #3 rst = 1;
    exp0.delete();
    exp1.delete();
    #1;
    chk("t5_v0", 32'(out0_valid), 32'd0);
    chk("t5_v1", 32'(out1_valid), 32'd0);
    chk("t5_d0", out0_data, 32'h0);
    chk("t5_d1", out1_data, 32'h0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    out0_ready = 1; out1_ready = 1;
    push(0, 32'h55);
    @(negedge clk);
    chk("t5_v1_quiet", 32'(out1_valid), 32'd0);
    drain("t5");

    // Delivered-word counters
    pulse_rst();
`ifdef DEMUX_STATS_EN
    chk("t6_cnt0_rst", cnt0, 32'd0);
    chk("t6_cnt1_rst", cnt1, 32'd0);
`endif
    for (int k = 0; k < 5; k++) push(0, 32'h60 + 32'(k));
    for (int k = 0; k < 3; k++) push(1, 32'h70 + 32'(k));
    drain("t6");
`ifdef DEMUX_STATS_EN
    chk("t6_cnt0", cnt0, 32'd5);
    chk("t6_cnt1", cnt1, 32'd3);
    pulse_rst();
    chk("t6_cnt0_clr", cnt0, 32'd0);
    chk("t6_cnt1_clr", cnt1, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1to2_buf.md
Name: demux1to2_buf

Overview:
- Inverse of the 2:1 datapath selector: one 32-bit producer stream is steered to one of two consumers by a `control` bit, with per-port buffering and valid/ready handshakes.
- Sits between a result source (e.g. ALU/memory stage) and two independent sinks (e.g. register write-back and store path).
- Lets either sink stall without losing data and without blocking transfers bound for the other sink.

Parameters:
- WIDTH, 32, data width of input and both outputs.
- DEPTH, 4, entries per output FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  word to route
- control  input  1  destination select; 0 -> port0, 1 -> port1; sampled with in_data
- in_valid  input  1  in_data/control valid
- in_ready  output  1  selected port can accept this cycle
- out0_data  output  WIDTH  head of port0 FIFO
- out0_valid  output  1  port0 FIFO non-empty
- out0_ready  input  1  port0 consumer accepts
- out1_data  output  WIDTH  head of port1 FIFO
- out1_valid  output  1  port1 FIFO non-empty
- out1_ready  input  1  port1 consumer accepts
- cnt0  output  32  port0 words delivered (only with DEMUX_STATS_EN)
- cnt1  output  32  port1 words delivered (only with DEMUX_STATS_EN)

Behaviour:
- Each port has its own circular FIFO of DEPTH entries.
  - Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - An occupancy counter of log2(DEPTH)+1 bits tracks fill level.
- in_ready is combinational: control==0 ? !full0 : !full1. It depends only on registered occupancy, never on outN_ready.
- Push: in_valid && in_ready at a clock edge writes in_data into FIFO[control] and advances its write pointer. The other FIFO is untouched.
- Pop: outN_valid && outN_ready at a clock edge advances FIFO N's read pointer.
- Latency: a word pushed into an empty FIFO appears on outN_data with outN_valid=1 in the next cycle. There is no combinational in-to-out path.
- Simultaneous push and pop on the same FIFO:
  - Non-empty and not full: both happen and occupancy is unchanged.
  - Full: push is refused (in_ready=0); the pop proceeds, and in_ready rises the following cycle.
  - Empty: only the push occurs, since outN_valid=0.
- Ordering: each port delivers words in push order. There is no ordering relation between the two ports.
- outN_data is forced to 0 whenever outN_valid=0.
- Sender obligation: while in_valid=1 and in_ready=0, in_data and control are held stable. The block does not check this.
- A stall on one port never affects pushes or pops on the other port.
- Reset, asynchronous and active-high, applies immediately:
  - pointers and occupancy counters clear to 0;
  - out0_valid = out1_valid = 0 and out0_data = out1_data = 0;
  - in_ready = 1 (both FIFOs empty);
  - cnt0 = cnt1 = 0.
- Reset asserted mid-transfer discards all buffered words. No partial state survives. The first cycle after deassertion behaves as a fresh start.
- FIFO storage contents need no reset.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - ports cnt0/cnt1 exist;
  - cntN increments by 1 on each pop from port N;
  - the counters wrap from 2^32-1 to 0;
  - both clear on rst.
- Undefined: cnt0/cnt1 ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic routing: push 0xAAAA0001 with control=0, then 0xBBBB0002 with control=1, both outN_ready=1 -> out0 shows 0xAAAA0001 and out1 shows 0xBBBB0002, each one cycle after its push, each valid for exactly one cycle.
- Fill and full: out0_ready=0, push 4 words 0x10..0x13 to port0 -> in_ready=0 while control=0. Switch control=1 -> in_ready=1, and 0x20 is accepted and delivered on out1.
- Full with simultaneous pop: port0 full, in_valid=1, control=0, then assert out0_ready -> that cycle 0x10 pops and the push is refused. Next cycle in_ready=1 and the push is accepted. Drained order is 0x11, 0x12, 0x13, new word.
- Wrap-around: stream 10 words 0x0..0x9 to port1 with out1_ready toggling 1,0,1,0 -> all 10 received in order with no duplicates, and pointers wrap at least twice.
- Reset mid-operation: 3 words buffered in port0 and 2 in port1, assert rst asynchronously between edges -> all outputs immediately take reset values, in_ready=1. After release, a new push of 0x55 emerges alone on the selected port.
- Stats (DEMUX_STATS_EN): deliver 5 words on port0 and 3 on port1 -> cnt0=5, cnt1=3. After rst both are 0.
